// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the single L2 request port between icache (port 0) and dcache (port 1).
// Optional perf counters are enabled by defining L2_ARB_PERF_CNT_EN.

package l2_arb_pkg;
  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memory_operation_e;
endpackage

module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [XLEN-1:0]   ic_req_address,
  input  memory_operation_e ic_req_type,
  input  logic              ic_req_valid,
  input  logic [XLEN-1:0]   ic_word_to_store,
  output logic [XLEN-1:0]   ic_fetched_word,
  output logic              ic_fetched_word_valid,

  input  logic [XLEN-1:0]   dc_req_address,
  input  memory_operation_e dc_req_type,
  input  logic              dc_req_valid,
  input  logic [XLEN-1:0]   dc_word_to_store,
  output logic [XLEN-1:0]   dc_fetched_word,
  output logic              dc_fetched_word_valid,

  output logic [XLEN-1:0]   l2_req_address,
  output memory_operation_e l2_req_type,
  output logic              l2_req_valid,
  output logic [XLEN-1:0]   l2_word_to_store,
  input  logic [XLEN-1:0]   l2_fetched_word,
  input  logic              l2_fetched_word_valid
`ifdef L2_ARB_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] ic_grant_count,
  output logic [CNT_WIDTH-1:0] dc_grant_count,
  output logic [CNT_WIDTH-1:0] conflict_count
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IC = 2'd1,
    GRANT_DC = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   last_grant_q;
  logic   last_grant_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // last_grant holds the port served most recently, so a tie goes to the other one.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (ic_req_valid && dc_req_valid) begin
          state_d = last_grant_q ? GRANT_IC : GRANT_DC;
        end else if (ic_req_valid) begin
          state_d = GRANT_IC;
        end else if (dc_req_valid) begin
          state_d = GRANT_DC;
        end
      end
      GRANT_IC: begin
        if (l2_fetched_word_valid) begin
          state_d      = RELEASE;
          last_grant_d = 1'b0;
        end
      end
      GRANT_DC: begin
        if (l2_fetched_word_valid) begin
          state_d      = RELEASE;
          last_grant_d = 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    l2_req_valid          = 1'b0;
    l2_req_address        = '0;
    l2_req_type           = LOAD;
    l2_word_to_store      = '0;
    ic_fetched_word_valid = 1'b0;
    dc_fetched_word_valid = 1'b0;
    unique case (state_q)
      GRANT_IC: begin
        l2_req_valid          = 1'b1;
        l2_req_address        = ic_req_address;
        l2_req_type           = ic_req_type;
        l2_word_to_store      = ic_word_to_store;
        ic_fetched_word_valid = l2_fetched_word_valid;
      end
      GRANT_DC: begin
        l2_req_valid          = 1'b1;
        l2_req_address        = dc_req_address;
        l2_req_type           = dc_req_type;
        l2_word_to_store      = dc_word_to_store;
        dc_fetched_word_valid = l2_fetched_word_valid;
      end
      default: begin
      end
    endcase
  end

  assign ic_fetched_word = l2_fetched_word;
  assign dc_fetched_word = l2_fetched_word;

`ifdef L2_ARB_PERF_CNT_EN
  logic ic_done;
  logic dc_done;
  logic conflict;

  assign ic_done  = (state_q == GRANT_IC) && l2_fetched_word_valid;
  assign dc_done  = (state_q == GRANT_DC) && l2_fetched_word_valid;
  assign conflict = (state_q == IDLE) && ic_req_valid && dc_req_valid;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ic_grant_count <= '0;
      dc_grant_count <= '0;
      conflict_count <= '0;
    end else begin
      if (ic_done && (ic_grant_count != '1)) begin
        ic_grant_count <= ic_grant_count + 1'b1;
      end
      if (dc_done && (dc_grant_count != '1)) begin
        dc_grant_count <= dc_grant_count + 1'b1;
      end
      if (conflict && (conflict_count != '1)) begin
        conflict_count <= conflict_count + 1'b1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  param_ok: assert property (@(posedge clk) (XLEN > 0) && (CNT_WIDTH > 0));

  ic_holds_valid: assert property (@(posedge clk) disable iff (!reset)
    (state_q == GRANT_IC) |-> ic_req_valid);

  dc_holds_valid: assert property (@(posedge clk) disable iff (!reset)
    (state_q == GRANT_DC) |-> dc_req_valid);

  acks_exclusive: assert property (@(posedge clk) disable iff (!reset)
    !(ic_fetched_word_valid && dc_fetched_word_valid));
`endif

endmodule
